// File: rtl/vmem_responder.sv
// Word-wide memory bus target with programmable wait cycles and byte-masked writes.
// Each accepted request completes with a one-cycle mem_ready pulse. Read data is registered.
module vmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic        mem_write,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  output logic        mem_ready,
  output logic        mem_resp_valid,
  output logic [31:0] mem_resp_rdata,
  output logic        err
);

  // state  | meaning
  // S_IDLE | waiting for mem_valid; request fields latched on accept
  // S_WAIT | counting down wait cycles from LATENCY-1
  // S_RESP | mem_ready pulse; write applied / read data registered on entry
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [29:0] r_addr;
  logic        r_write;
  logic [31:0] r_wdata;
  logic [3:0]  r_wmask;
  logic [31:0] r_rdata;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic [29:0]   w_req_addr;
  logic          w_req_write;
  logic [31:0]   w_req_wdata;
  logic [3:0]    w_req_wmask;
  logic          w_req_inrange;
  logic [AW-1:0] w_req_idx;
  logic          w_enter_resp;
  logic          w_unused;

  assign w_unused = ^mem_addr[1:0];

  // With LATENCY = 0 the RESP entry edge is also the accept edge, so take the live inputs.
  assign w_req_addr    = (r_state == S_IDLE) ? mem_addr[31:2] : r_addr;
  assign w_req_write   = (r_state == S_IDLE) ? mem_write      : r_write;
  assign w_req_wdata   = (r_state == S_IDLE) ? mem_wdata      : r_wdata;
  assign w_req_wmask   = (r_state == S_IDLE) ? mem_wmask      : r_wmask;
  assign w_req_inrange = (w_req_addr[29:AW] == '0);
  assign w_req_idx     = w_req_addr[AW-1:0];
  assign w_enter_resp  = (r_state != S_RESP) && (w_state_nxt == S_RESP);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (mem_valid) begin
          if (LATENCY == 0) begin
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = LAT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) w_state_nxt = S_RESP;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_wmask <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (r_state == S_IDLE && mem_valid) begin
        r_addr  <= mem_addr[31:2];
        r_write <= mem_write;
        r_wdata <= mem_wdata;
        r_wmask <= mem_wmask;
      end
      if (w_enter_resp && !w_req_write)
        r_rdata <= w_req_inrange ? r_mem[w_req_idx] : 32'h0000_0000;
    end
  end

  // Storage is deliberately not reset; rst_n only blocks writes while held low.
  always_ff @(posedge clk) begin
    if (rst_n && w_enter_resp && w_req_write && w_req_inrange) begin
      for (int b = 0; b < 4; b++)
        if (w_req_wmask[b]) r_mem[w_req_idx][8*b +: 8] <= w_req_wdata[8*b +: 8];
    end
  end

  assign mem_ready      = (r_state == S_RESP);
  assign mem_resp_valid = mem_ready && !r_write;
  assign err            = mem_ready && (r_addr[29:AW] != '0);
  assign mem_resp_rdata = r_rdata;

endmodule

// File: tb/tb_vmem_responder.sv
// Bench for vmem_responder: four instances (LATENCY 1, 0, 7, 4), table-driven vectors,
// a response scoreboard queue, and hand sequences for spacing, valid drop and mid-request reset.
module tb_vmem_responder;

  localparam int NI = 4;

  logic        clk;
  logic        rst_n;
  logic        v_valid [NI];
  logic [31:0] v_addr  [NI];
  logic        v_write [NI];
  logic [31:0] v_wdata [NI];
  logic [3:0]  v_wmask [NI];
  logic        o_ready [NI];
  logic        o_rv    [NI];
  logic [31:0] o_rdata [NI];
  logic        o_err   [NI];

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    bit          wr;
    logic [31:0] rdata;
    bit          err;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] rdata;
    bit          err;
  } vec_t;

  function automatic int lat_of(input int i);
    case (i)
      0:       return 1;
      1:       return 0;
      2:       return 7;
      default: return 4;
    endcase
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    vmem_responder #(
      .DEPTH_WORDS(1024),
      .LATENCY(g == 0 ? 1 : g == 1 ? 0 : g == 2 ? 7 : 4)
    ) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .mem_valid      (v_valid[g]),
      .mem_addr       (v_addr[g]),
      .mem_write      (v_write[g]),
      .mem_wdata      (v_wdata[g]),
      .mem_wmask      (v_wmask[g]),
      .mem_ready      (o_ready[g]),
      .mem_resp_valid (o_rv[g]),
      .mem_resp_rdata (o_rdata[g]),
      .err            (o_err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // resp_valid and err may only accompany mem_ready
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NI; i++) begin
        chk("rv_outside_ready",  {31'b0, o_rv[i]  & ~o_ready[i]}, 32'd0);
        chk("err_outside_ready", {31'b0, o_err[i] & ~o_ready[i]}, 32'd0);
      end
    end
  end

  // Called just after a posedge; returns just after the posedge that ends RESP, valid dropped.
  task automatic req(input int i, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] mask, input logic [31:0] exp_rdata, input bit exp_err,
                     output int rdy_cyc);
    exp_t e;
    int   n;
    bit   got;
    e.wr = wr; e.rdata = exp_rdata; e.err = exp_err;
    sb_q.push_back(e);
    v_addr[i] = addr; v_write[i] = wr; v_wdata[i] = wdata; v_wmask[i] = mask;
    v_valid[i] = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (o_ready[i]) got = 1'b1;
    end
    rdy_cyc = cyc;
    chk("ready_seen", {31'b0, got}, 32'd1);
    if (got) begin
      e = sb_q.pop_front();
      chk("latency", n, lat_of(i) + 1);
      chk("resp_valid", {31'b0, o_rv[i]}, {31'b0, !e.wr});
      chk("err", {31'b0, o_err[i]}, {31'b0, e.err});
      if (!e.wr) chk("rdata", o_rdata[i], e.rdata);
    end else begin
      void'(sb_q.pop_front());
    end
    @(posedge clk); #1;
    v_valid[i] = 1'b0;
    chk("ready_one_cycle", {31'b0, o_ready[i]}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl [17];
    int   r1, r2, rc, n;
    bit   got;

    tbl[0]  = '{1'b1, 32'h0000_0100, 32'h1122_3344, 4'hF, 32'h0,         1'b0};
    tbl[1]  = '{1'b1, 32'h0000_0104, 32'h5566_7788, 4'hF, 32'h0,         1'b0};
    tbl[2]  = '{1'b0, 32'h0000_0100, 32'h0,         4'hF, 32'h1122_3344, 1'b0};
    tbl[3]  = '{1'b0, 32'h0000_0104, 32'h0,         4'hF, 32'h5566_7788, 1'b0};
    tbl[4]  = '{1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b0};
    tbl[5]  = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 32'h0,         1'b0};
    tbl[6]  = '{1'b0, 32'h0000_0020, 32'h0,         4'hF, 32'hFFBB_FFDD, 1'b0};
    tbl[7]  = '{1'b1, 32'h0000_0020, 32'h1234_5678, 4'h0, 32'h0,         1'b0};
    tbl[8]  = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'hFFBB_FFDD, 1'b0};
    tbl[9]  = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 32'h0,         1'b0};
    tbl[10] = '{1'b0, 32'h0000_1000, 32'h0,         4'hF, 32'h0,         1'b1};
    tbl[11] = '{1'b1, 32'h0000_1000, 32'h1234_5678, 4'hF, 32'h0,         1'b1};
    tbl[12] = '{1'b0, 32'h0000_0000, 32'h0,         4'hF, 32'hCAFE_F00D, 1'b0};
    tbl[13] = '{1'b0, 32'h0000_0103, 32'h0,         4'h0, 32'h1122_3344, 1'b0};
    tbl[14] = '{1'b1, 32'h0000_0FFC, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0};
    tbl[15] = '{1'b0, 32'h0000_0FFC, 32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0};
    tbl[16] = '{1'b0, 32'h8000_0100, 32'h0,         4'hF, 32'h0,         1'b1};

    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      v_valid[i] = 1'b0; v_addr[i] = '0; v_write[i] = 1'b0; v_wdata[i] = '0; v_wmask[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("reset_ready", {31'b0, o_ready[i]}, 32'd0);
      chk("reset_rv",    {31'b0, o_rv[i]},    32'd0);
      chk("reset_rdata", o_rdata[i],          32'd0);
      chk("reset_err",   {31'b0, o_err[i]},   32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 17; k++)
      req(0, tbl[k].wr, tbl[k].addr, tbl[k].wdata, tbl[k].mask, tbl[k].rdata, tbl[k].err, rc);

    // valid held through the RESP cycle must not start a second transaction
    v_addr[0] = 32'h100; v_write[0] = 1'b0; v_valid[0] = 1'b1;
    for (int k = 0; k < 2; k++) begin @(posedge clk); #1; end
    chk("reaccept_ready", {31'b0, o_ready[0]}, 32'd1);
    @(posedge clk); #1;
    v_valid[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("no_reaccept", {31'b0, o_ready[0]}, 32'd0);
    end

    for (int i = 0; i < 3; i++) begin
      req(i, 1'b1, 32'h200, 32'hC0DE_0000 | i, 4'hF, 32'h0, 1'b0, rc);
      req(i, 1'b1, 32'h204, 32'hBEEF_0000 | i, 4'hF, 32'h0, 1'b0, rc);
      req(i, 1'b0, 32'h200, 32'h0, 4'hF, 32'hC0DE_0000 | i, 1'b0, r1);
      req(i, 1'b0, 32'h204, 32'h0, 4'hF, 32'hBEEF_0000 | i, 1'b0, r2);
      chk("b2b_spacing", r2 - r1, lat_of(i) + 2);
    end

    // valid withdrawn during WAIT: latched request still completes
    v_addr[2] = 32'h80; v_write[2] = 1'b1; v_wdata[2] = 32'h0BAD_F00D; v_wmask[2] = 4'hF;
    v_valid[2] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    v_valid[2] = 1'b0; v_addr[2] = 32'h84; v_wdata[2] = 32'h0; v_write[2] = 1'b0;
    n = 2; got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (o_ready[2]) got = 1'b1;
    end
    chk("drop_ready_seen", {31'b0, got}, 32'd1);
    chk("drop_latency", n, 8);
    chk("drop_rv", {31'b0, o_rv[2]}, 32'd0);
    @(posedge clk); #1;
    req(2, 1'b0, 32'h80, 32'h0, 4'hF, 32'h0BAD_F00D, 1'b0, rc);

    // reset two cycles into a LATENCY=4 write
    req(3, 1'b1, 32'h40, 32'hA5A5_A5A5, 4'hF, 32'h0, 1'b0, rc);
    req(3, 1'b0, 32'h40, 32'h0, 4'hF, 32'hA5A5_A5A5, 1'b0, rc);
    v_addr[3] = 32'h40; v_write[3] = 1'b1; v_wdata[3] = 32'h5A5A_5A5A; v_wmask[3] = 4'hF;
    v_valid[3] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("pre_reset_ready", {31'b0, o_ready[3]}, 32'd0);
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", {31'b0, o_ready[3]}, 32'd0);
    chk("midrst_rv",    {31'b0, o_rv[3]},    32'd0);
    chk("midrst_rdata", o_rdata[3],          32'd0);
    chk("midrst_err",   {31'b0, o_err[3]},   32'd0);
    v_valid[3] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("in_reset_ready", {31'b0, o_ready[3]}, 32'd0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("aborted_no_ready", {31'b0, o_ready[3]}, 32'd0);
    end
    req(3, 1'b0, 32'h40, 32'h0, 4'hF, 32'hA5A5_A5A5, 1'b0, rc);

    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
